// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : Pipelined immediate generator with 1-cycle latency, feeding a
//            2-entry skid buffer (OUT + SKID) under valid/ready handshakes.
//            Supports I/S/B/J/U, shamt and CSR-zimm formats at XLEN 32/64.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSel,
    input  logic [31:0]      inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] c_SEL_I     = 3'b000;
    localparam logic [2:0] c_SEL_S     = 3'b001;
    localparam logic [2:0] c_SEL_B     = 3'b010;
    localparam logic [2:0] c_SEL_J     = 3'b011;
    localparam logic [2:0] c_SEL_U     = 3'b100;
    localparam logic [2:0] c_SEL_SHAMT = 3'b101;
    localparam logic [2:0] c_SEL_ZIMM  = 3'b110;

    logic [31:0]      w_base;
    logic             w_ill;
    logic [WIDTH-1:0] w_imm;
    logic             w_unused;
    logic             w_accept;
    logic             w_drain;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_imm;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_ill;

    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_ill;

    // The opcode field never contributes to any immediate.
    assign w_unused = ^inst[6:0];

    // Decode the 32-bit form of the immediate; sign-extending formats are
    // already extended to 32 bits here, zero-extending ones have zero tops.
    always_comb begin
        w_base = 32'd0;
        w_ill  = 1'b0;
        case (ImmSel)
            c_SEL_I:     w_base = {{20{inst[31]}}, inst[31:20]};
            c_SEL_S:     w_base = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            c_SEL_B:     w_base = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            c_SEL_J:     w_base = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            c_SEL_U:     w_base = {inst[31:12], 12'd0};
            // RV64 shift amounts carry a sixth bit in inst[25].
            c_SEL_SHAMT: w_base = {26'd0, (WIDTH == 64) ? inst[25] : 1'b0, inst[24:20]};
            c_SEL_ZIMM:  w_base = {27'd0, inst[19:15]};
            default: begin
                w_base = 32'd0;
                w_ill  = 1'b1;
            end
        endcase
    end

    generate
        if (WIDTH == 64) begin : g_xlen64
            // Only I/S/B/J/U (selects 0..4) carry their sign into the upper word.
            logic w_sx;
            assign w_sx  = (ImmSel <= c_SEL_U);
            assign w_imm = {{32{w_sx & w_base[31]}}, w_base};
        end else begin : g_xlen32
            assign w_imm = w_base;
        end
    endgenerate

    // Ready only depends on registered state so downstream ready never
    // reaches upstream through a combinational path.
    assign in_ready = !r_skid_valid && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_out_valid && out_ready;

    // OUT/SKID slot update: reset, then flush, then normal move/load/hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_tag    <= '0;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
            r_skid_ill   <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || w_drain) begin
            if (r_skid_valid) begin
                // SKID holds the older entry; it moves up first.
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_out_tag    <= r_skid_tag;
                r_out_ill    <= r_skid_ill;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= w_imm;
                r_out_tag   <= in_tag;
                r_out_ill   <= w_ill;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // OUT stalled: park the new entry in SKID.
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_tag   <= in_tag;
            r_skid_ill   <= w_ill;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_tag     = r_out_tag;
    assign out_illegal = r_out_ill;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Directed self-checking bench for imm_gen_pipe at WIDTH 32 and 64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready_32;
    logic        in_ready_64;
    logic [2:0]  ImmSel;
    logic [31:0] inst;
    logic [31:0] in_tag;
    logic        out_ready;
    logic        out_valid_32;
    logic [31:0] out_imm_32;
    logic [31:0] out_tag_32;
    logic        out_ill_32;
    logic        out_valid_64;
    logic [63:0] out_imm_64;
    logic [31:0] out_tag_64;
    logic        out_ill_64;

    int n_chk;
    int n_pass;

    imm_gen_pipe #(.WIDTH(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_32),
        .ImmSel(ImmSel), .inst(inst), .in_tag(in_tag), .out_valid(out_valid_32),
        .out_ready(out_ready), .out_imm(out_imm_32), .out_tag(out_tag_32),
        .out_illegal(out_ill_32)
    );

    imm_gen_pipe #(.WIDTH(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_64),
        .ImmSel(ImmSel), .inst(inst), .in_tag(in_tag), .out_valid(out_valid_64),
        .out_ready(out_ready), .out_imm(out_imm_64), .out_tag(out_tag_64),
        .out_illegal(out_ill_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] ins,
                         input logic [31:0] tg);
        in_valid = v;
        ImmSel   = sel;
        inst     = ins;
        in_tag   = tg;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] ins;
        logic [63:0] exp32;
        logic        ill;
    } vec_t;

    vec_t vecs[9];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        vecs[0] = '{3'b000, 32'hFFF00093, 64'hFFFF_FFFF, 1'b0};
        vecs[1] = '{3'b001, 32'hFE512E23, 64'hFFFF_FFFC, 1'b0};
        vecs[2] = '{3'b010, 32'hFE000EE3, 64'hFFFF_FFFC, 1'b0};
        vecs[3] = '{3'b011, 32'h001000EF, 64'h0000_0800, 1'b0};
        vecs[4] = '{3'b100, 32'h123450B7, 64'h1234_5000, 1'b0};
        vecs[5] = '{3'b101, 32'h01F09093, 64'h0000_001F, 1'b0};
        vecs[6] = '{3'b110, 32'h000FD073, 64'h0000_001F, 1'b0};
        vecs[7] = '{3'b111, 32'hFFFFFFFF, 64'h0000_0000, 1'b1};
        vecs[8] = '{3'b000, 32'hFFF00093, 64'hFFFF_FFFF, 1'b0};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        step(); step();
        chk("rst_out_valid", {63'd0, out_valid_32}, 64'd0);
        chk("rst_out_imm",   {32'd0, out_imm_32}, 64'd0);
        chk("rst_out_tag",   {32'd0, out_tag_32}, 64'd0);
        chk("rst_out_ill",   {63'd0, out_ill_32}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready_32}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready_32}, 64'd1);

        // Format sweep at WIDTH=32, one entry per cycle.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].sel, vecs[i].ins, 32'd100 + 32'(i));
            step();
            chk($sformatf("fmt%0d_valid", i), {63'd0, out_valid_32}, 64'd1);
            chk($sformatf("fmt%0d_imm", i),   {32'd0, out_imm_32}, vecs[i].exp32);
            chk($sformatf("fmt%0d_tag", i),   {32'd0, out_tag_32}, 64'd100 + 64'(i));
            chk($sformatf("fmt%0d_ill", i),   {63'd0, out_ill_32}, {63'd0, vecs[i].ill});
        end

        // WIDTH=64 specifics, with the WIDTH=32 instance as a contrast.
        drive(1'b1, 3'b100, 32'h823450B7, 32'd200);
        step();
        chk("x64_u_imm", out_imm_64, 64'hFFFF_FFFF_8234_5000);
        chk("x32_u_imm", {32'd0, out_imm_32}, 64'h8234_5000);
        drive(1'b1, 3'b101, 32'h03F09093, 32'd201);
        step();
        chk("x64_shamt_imm", out_imm_64, 64'h3F);
        chk("x32_shamt_imm", {32'd0, out_imm_32}, 64'h1F);
        drive(1'b1, 3'b110, 32'hFFFFFFFF, 32'd202);
        step();
        chk("x64_zimm_imm", out_imm_64, 64'h1F);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        step();
        chk("idle_out_valid", {63'd0, out_valid_32}, 64'd0);

        // Back-pressure: tag1 in OUT, tag2 in SKID, tag3 held upstream.
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h00100093, 32'd1);
        step();
        chk("bp_t1_tag", {32'd0, out_tag_32}, 64'd1);
        chk("bp_t1_in_ready", {63'd0, in_ready_32}, 64'd1);
        drive(1'b1, 3'b000, 32'h00200093, 32'd2);
        step();
        chk("bp_t2_in_ready", {63'd0, in_ready_32}, 64'd0);
        chk("bp_t2_out_tag", {32'd0, out_tag_32}, 64'd1);
        drive(1'b1, 3'b000, 32'h00300093, 32'd3);
        step();
        chk("bp_hold_tag", {32'd0, out_tag_32}, 64'd1);
        chk("bp_hold_imm", {32'd0, out_imm_32}, 64'd1);
        chk("bp_hold_in_ready", {63'd0, in_ready_32}, 64'd0);
        step();
        chk("bp_hold2_tag", {32'd0, out_tag_32}, 64'd1);
        chk("bp_hold2_valid", {63'd0, out_valid_32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_rel_t2_tag", {32'd0, out_tag_32}, 64'd2);
        chk("bp_rel_t2_imm", {32'd0, out_imm_32}, 64'd2);
        chk("bp_rel_in_ready", {63'd0, in_ready_32}, 64'd1);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("bp_rel_t3_tag", {32'd0, out_tag_32}, 64'd3);
        chk("bp_rel_t3_valid", {63'd0, out_valid_32}, 64'd1);
        step();
        chk("bp_drained", {63'd0, out_valid_32}, 64'd0);

        // Flush with OUT and SKID full and an input presented.
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'd0, 32'd10);
        step();
        drive(1'b1, 3'b000, 32'd0, 32'd11);
        step();
        flush = 1'b1;
        drive(1'b1, 3'b000, 32'd0, 32'd12);
        step();
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("fl_out_valid", {63'd0, out_valid_32}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready_32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("fl_no_ghost", {63'd0, out_valid_32}, 64'd0);

        // Flush while in_ready=1: the presented entry is still dropped.
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'd0, 32'd13);
        step();
        flush = 1'b1;
        drive(1'b1, 3'b000, 32'd0, 32'd14);
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("fl2_out_valid", {63'd0, out_valid_32}, 64'd0);
        step();
        chk("fl2_no_ghost", {63'd0, out_valid_32}, 64'd0);

        // Reset mid-stream, then 1-cycle latency on the first new entry.
        drive(1'b1, 3'b000, 32'h00500093, 32'd20);
        step();
        chk("mr_pre_tag", {32'd0, out_tag_32}, 64'd20);
        rst = 1'b1;
        drive(1'b1, 3'b000, 32'h00600093, 32'd21);
        step();
        chk("mr_out_valid", {63'd0, out_valid_32}, 64'd0);
        chk("mr_out_imm", {32'd0, out_imm_32}, 64'd0);
        chk("mr_out_tag", {32'd0, out_tag_32}, 64'd0);
        chk("mr_in_ready", {63'd0, in_ready_32}, 64'd0);
        rst = 1'b0;
        drive(1'b1, 3'b000, 32'h7FF00093, 32'd22);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        chk("mr_new_valid", {63'd0, out_valid_32}, 64'd1);
        chk("mr_new_tag", {32'd0, out_tag_32}, 64'd22);
        chk("mr_new_imm", {32'd0, out_imm_32}, 64'h7FF);
        step();
        chk("mr_end_valid", {63'd0, out_valid_32}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised successor to the decode-stage immediate generator. It accepts an instruction word, an immediate-format select and a passthrough tag under a valid/ready handshake. It produces the sign- or zero-extended immediate one cycle later through a 2-entry skid buffer. It adds XLEN generalisation (32/64), shamt and CSR-zimm formats, an illegal-select flag, back-pressure and flush, and sits between the fetch/decode boundary and the ID/EX register.

Parameters:
WIDTH, 32, datapath/immediate width; legal values 32 or 64.
TAG_W, 32, width of the passthrough tag (PC or ROB id).

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  drop all buffered entries.
in_valid  input  1  upstream presents an entry.
in_ready  output  1  block can accept an entry this cycle.
ImmSel  input  3  format select.
inst  input  32  instruction word.
in_tag  input  TAG_W  tag travelling with the entry.
out_valid  output  1  out_* fields valid.
out_ready  input  1  downstream accepts the output entry.
out_imm  output  WIDTH  generated immediate.
out_tag  output  TAG_W  tag of the output entry.
out_illegal  output  1  entry used an unsupported ImmSel.

Behaviour:
- Format decode is combinational on the input side; the result is registered. All extensions go to WIDTH.
  - 000 I: sext(inst[31:20]).
  - 001 S: sext({inst[31:25],inst[11:7]}).
  - 010 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 011 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). This is the full RV J-type, including bit 20 from inst[31].
  - 100 U: sext({inst[31:12],12'b0}). The value is pre-shifted, and sign-extended when WIDTH=64.
  - 101 shamt: zext(inst[24:20]) when WIDTH=32; zext(inst[25:20]) when WIDTH=64.
  - 110 CSR zimm: zext(inst[19:15]).
  - 111: imm=0, illegal=1.
  - Every other select gives illegal=0.
- Storage: output register (OUT) plus one skid register (SKID), each holding {valid, imm, tag, illegal}.
- in_ready = !SKID.valid && !rst. in_ready is a registered-state function and does not depend combinationally on out_ready.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Cycle rules, evaluated when flush=0:
  - OUT empty or draining, SKID empty: an accepted entry loads OUT. Latency is 1 cycle, accept at edge N gives out_valid at N+1.
  - OUT draining, SKID full: SKID moves to OUT and SKID clears. in_ready was 0, so nothing is accepted.
  - OUT full and not draining, accept: the entry loads SKID, and in_ready drops next cycle.
  - OUT full and not draining, no accept: hold all state. out_* remains stable while out_valid && !out_ready.
  - No accept and OUT draining with SKID empty: OUT.valid clears.
- Ordering: entries leave in acceptance order. No entry is duplicated or lost except by flush/rst.
- Flush (priority over accept/drain): OUT.valid and SKID.valid clear at the edge. An input presented in the flush cycle is dropped, even if in_ready=1. in_ready=1 in the following cycle.
- Reset: OUT and SKID valid=0, out_imm=0, out_tag=0, out_illegal=0, in_ready=0 while rst=1. Reset mid-stream discards all entries. rst has priority over flush.
- Data fields of an invalid slot are don't-care except after reset, when they are 0.
- Throughput: 1 entry/cycle sustained when out_ready=1.

Test Plan:
- Formats, WIDTH=32, out_ready=1, one per cycle. Each output appears 1 cycle after accept, tags preserved:
  - 0xFFF00093/I → 0xFFFFFFFF.
  - 0xFE512E23/S → 0xFFFFFFFC.
  - 0xFE000EE3/B → 0xFFFFFFFC.
  - 0x001000EF/J → 0x00000800.
  - 0x123450B7/U → 0x12345000.
  - 0x01F09093/shamt → 0x0000001F.
  - 0x000FD073/zimm → 0x0000001F.
- ImmSel=111, inst=0xFFFFFFFF → out_imm=0, out_illegal=1. The next legal entry has out_illegal=0.
- WIDTH=64:
  - 0x823450B7/U → 0xFFFFFFFF82345000.
  - 0x03F09093/shamt → 0x3F.
- Back-pressure:
  - Hold out_ready=0 and stream tags 1,2,3. Tag1 sits in OUT, tag2 in SKID, in_ready=0 from the cycle after tag2 is accepted, and tag3 is held upstream.
  - Raise out_ready. Outputs are 1,2,3 in consecutive cycles with out_* stable while stalled.
- Flush with OUT and SKID full, plus in_valid=1 in the same cycle: next cycle out_valid=0, in_ready=1, and the flush-cycle entry never appears.
- Assert rst for 1 cycle mid-stream: out_valid=0, out_imm=0, out_tag=0, in_ready=0 during reset. After release, the first new entry emerges with 1-cycle latency.
